// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier between N requesters.
// Unpacks the granted operands, issues one operation at a time and aborts stalled results via a watchdog.
module fpu_mul_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_valid_i,
   input  logic [32*N-1:0] req_x_i,
   input  logic [32*N-1:0] req_y_i,
   output logic [N-1:0]    req_ready_o,
   output logic [N-1:0]    rsp_valid_o,
   output logic [31:0]     rsp_z_o,
   output logic            rsp_invalid_o,
   output logic            rsp_overflow_o,
   output logic            rsp_timeout_o,
   output logic            mul_rst_o,
   output logic            mul_valid_o,
   output logic            mul_x_sign_o,
   output logic            mul_y_sign_o,
   output logic [7:0]      mul_x_exp_o,
   output logic [7:0]      mul_y_exp_o,
   output logic [22:0]     mul_x_frac_o,
   output logic [22:0]     mul_y_frac_o,
   output logic            mul_x_inf_o,
   output logic            mul_y_inf_o,
   output logic            mul_x_nan_o,
   output logic            mul_y_nan_o,
   input  logic            mul_valid_i,
   input  logic [31:0]     mul_z_i,
   input  logic            mul_invalid_i,
   input  logic            mul_overflow_i
);

   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

   state_t        state, state_next;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt;
   logic [PW-1:0] win;
   logic          found;
   logic [31:0]   x_q, y_q;
   logic [31:0]   sel_x, sel_y;
   logic [CW-1:0] cnt;
   logic [31:0]   z_q;
   logic          inv_q, ovf_q, to_q;
   logic          expire;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      for (int i = 1; i <= N; i++) begin
         int idx;
         idx = (int'(ptr) + i) % N;
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
      sel_x = req_x_i[32*int'(win) +: 32];
      sel_y = req_y_i[32*int'(win) +: 32];
   end

   assign expire = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (mul_valid_i || expire) state_next = RESPOND;
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr   <= PW'(N - 1);
         gnt   <= '0;
         x_q   <= '0;
         y_q   <= '0;
         cnt   <= '0;
         z_q   <= '0;
         inv_q <= 1'b0;
         ovf_q <= 1'b0;
         to_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  x_q <= sel_x;
                  y_q <= sel_y;
                  gnt <= win;
                  ptr <= win;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               // A result arriving on the final watchdog cycle still counts as a success.
               if (mul_valid_i) begin
                  z_q   <= mul_z_i;
                  inv_q <= mul_invalid_i;
                  ovf_q <= mul_overflow_i;
                  to_q  <= 1'b0;
               end else if (expire) begin
                  z_q   <= 32'h7FFF_FFFF;
                  inv_q <= 1'b0;
                  ovf_q <= 1'b0;
                  to_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o    = (rst_ni && state == IDLE && found) ? (N'(1) << win) : '0;
   assign rsp_valid_o    = (state == RESPOND) ? (N'(1) << gnt) : '0;
   assign mul_valid_o    = (state == ISSUE);
   assign mul_rst_o      = ~rst_ni | (state == RESPOND && to_q);
   assign rsp_z_o        = z_q;
   assign rsp_invalid_o  = inv_q;
   assign rsp_overflow_o = ovf_q;
   assign rsp_timeout_o  = to_q;

   assign mul_x_sign_o = x_q[31];
   assign mul_x_exp_o  = x_q[30:23];
   assign mul_x_frac_o = x_q[22:0];
   assign mul_y_sign_o = y_q[31];
   assign mul_y_exp_o  = y_q[30:23];
   assign mul_y_frac_o = y_q[22:0];
   assign mul_x_inf_o  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == '0);
   assign mul_x_nan_o  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != '0);
   assign mul_y_inf_o  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == '0);
   assign mul_y_nan_o  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != '0);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter; the bench itself plays the multiplier,
// answering each issue with a hand-chosen result and latency.
module tb_fpu_mul_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_x, req_y;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [31:0]     rsp_z;
   logic            rsp_invalid, rsp_overflow, rsp_timeout;
   logic            mul_rst, mul_valid;
   logic            mul_x_sign, mul_y_sign;
   logic [7:0]      mul_x_exp, mul_y_exp;
   logic [22:0]     mul_x_frac, mul_y_frac;
   logic            mul_x_inf, mul_y_inf, mul_x_nan, mul_y_nan;
   logic            mul_done;
   logic [31:0]     mul_z;
   logic            mul_invalid, mul_overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] rr_x [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

   always #5 clk = ~clk;

   fpu_mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_x_i(req_x), .req_y_i(req_y),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_z_o(rsp_z),
      .rsp_invalid_o(rsp_invalid), .rsp_overflow_o(rsp_overflow), .rsp_timeout_o(rsp_timeout),
      .mul_rst_o(mul_rst), .mul_valid_o(mul_valid),
      .mul_x_sign_o(mul_x_sign), .mul_y_sign_o(mul_y_sign),
      .mul_x_exp_o(mul_x_exp), .mul_y_exp_o(mul_y_exp),
      .mul_x_frac_o(mul_x_frac), .mul_y_frac_o(mul_y_frac),
      .mul_x_inf_o(mul_x_inf), .mul_y_inf_o(mul_y_inf),
      .mul_x_nan_o(mul_x_nan), .mul_y_nan_o(mul_y_nan),
      .mul_valid_i(mul_done), .mul_z_i(mul_z),
      .mul_invalid_i(mul_invalid), .mul_overflow_i(mul_overflow)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic sampleOutputs;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int k, input logic [31:0] x, input logic [31:0] y, input logic v);
      req_x[32*k +: 32] = x;
      req_y[32*k +: 32] = y;
      req_valid[k]      = v;
   endtask

   // Waits (bounded) for a grant, leaving time at the negedge of the grant cycle.
   task automatic waitGrant(input logic [N-1:0] exp, input string tag);
      for (int i = 0; i < 10; i++) begin
         sampleOutputs();
         if (req_ready != '0) break;
         stepCycle();
      end
      checkOutput(tag, 32'(req_ready), 32'(exp));
   endtask

   task automatic respondOp(input logic [31:0] z, input logic inv, input logic ovf);
      mul_done     = 1'b1;
      mul_z        = z;
      mul_invalid  = inv;
      mul_overflow = ovf;
      stepCycle();
      mul_done     = 1'b0;
   endtask

   initial begin
      logic early;
      rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
      mul_done = 1'b0; mul_z = '0; mul_invalid = 1'b0; mul_overflow = 1'b0;

      stepCycle();
      stepCycle();
      sampleOutputs();
      checkOutput("reset_mul_rst", 32'(mul_rst), 32'd1);
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_mul_valid", 32'(mul_valid), 32'd0);
      checkOutput("reset_rsp_z", rsp_z, 32'd0);

      for (int k = 0; k < N; k++) applyStimulus(k, rr_x[k], 32'h3F80_0000, 1'b1);
      stepCycle();
      rst_n = 1'b1;

      // Round robin: echo x so each response identifies whose operand was issued.
      for (int r = 0; r < 5; r++) begin
         int k;
         k = r % N;
         waitGrant(N'(1) << k, "rr_grant");
         stepCycle();
         sampleOutputs();
         checkOutput("rr_mul_valid", 32'(mul_valid), 32'd1);
         checkOutput("rr_no_overlap", 32'(req_ready), 32'd0);
         stepCycle();
         respondOp({mul_x_sign, mul_x_exp, mul_x_frac}, 1'b0, 1'b0);
         sampleOutputs();
         checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(N'(1) << k));
         checkOutput("rr_rsp_z", rsp_z, rr_x[k]);
         stepCycle();
      end
      req_valid = '0;

      // Single request 1.0 * 2.0
      applyStimulus(0, 32'h3F80_0000, 32'h4000_0000, 1'b1);
      waitGrant(4'b0001, "single_grant");
      stepCycle();
      req_valid = '0;
      sampleOutputs();
      checkOutput("single_mul_valid", 32'(mul_valid), 32'd1);
      checkOutput("single_x_exp", 32'(mul_x_exp), 32'h7F);
      checkOutput("single_y_exp", 32'(mul_y_exp), 32'h80);
      checkOutput("single_x_frac", 32'(mul_x_frac), 32'd0);
      stepCycle();
      sampleOutputs();
      checkOutput("single_mul_valid_pulse", 32'(mul_valid), 32'd0);
      respondOp(32'h4000_0000, 1'b0, 1'b0);
      sampleOutputs();
      checkOutput("single_rsp_valid", 32'(rsp_valid), 32'b0001);
      checkOutput("single_rsp_z", rsp_z, 32'h4000_0000);
      checkOutput("single_flags", {29'd0, rsp_invalid, rsp_overflow, rsp_timeout}, 32'd0);
      stepCycle();
      sampleOutputs();
      checkOutput("single_rsp_pulse", 32'(rsp_valid), 32'd0);
      stepCycle();

      // Operand classes: +inf * 0
      applyStimulus(1, 32'h7F80_0000, 32'h0000_0000, 1'b1);
      waitGrant(4'b0010, "inf_grant");
      stepCycle();
      req_valid = '0;
      sampleOutputs();
      checkOutput("inf_x_inf", 32'(mul_x_inf), 32'd1);
      checkOutput("inf_x_nan", 32'(mul_x_nan), 32'd0);
      checkOutput("inf_y_inf", 32'(mul_y_inf), 32'd0);
      stepCycle();
      respondOp(32'h7FFF_FFFF, 1'b1, 1'b0);
      sampleOutputs();
      checkOutput("inf_rsp_valid", 32'(rsp_valid), 32'b0010);
      checkOutput("inf_rsp_z", rsp_z, 32'h7FFF_FFFF);
      checkOutput("inf_rsp_invalid", 32'(rsp_invalid), 32'd1);
      stepCycle();

      applyStimulus(2, 32'h7FC0_0001, 32'hBF80_0000, 1'b1);
      waitGrant(4'b0100, "nan_grant");
      stepCycle();
      req_valid = '0;
      sampleOutputs();
      checkOutput("nan_x_nan", 32'(mul_x_nan), 32'd1);
      checkOutput("nan_x_inf", 32'(mul_x_inf), 32'd0);
      checkOutput("nan_x_frac", 32'(mul_x_frac), 32'h40_0001);
      checkOutput("nan_y_sign", 32'(mul_y_sign), 32'd1);
      stepCycle();
      respondOp(32'h7F80_0000, 1'b0, 1'b1);
      sampleOutputs();
      checkOutput("nan_rsp_overflow", 32'(rsp_overflow), 32'd1);
      checkOutput("nan_rsp_invalid", 32'(rsp_invalid), 32'd0);
      stepCycle();

      // Timeout: no result ever arrives
      applyStimulus(0, 32'h4000_0000, 32'h4000_0000, 1'b1);
      waitGrant(4'b0001, "to_grant");
      early = 1'b0;
      for (int i = 1; i <= TIMEOUT + 1; i++) begin
         stepCycle();
         if (i == 1) req_valid = '0;
         sampleOutputs();
         early = early | (rsp_valid != '0) | mul_rst;
      end
      checkOutput("to_early", 32'(early), 32'd0);
      stepCycle();
      sampleOutputs();
      checkOutput("to_rsp_valid", 32'(rsp_valid), 32'b0001);
      checkOutput("to_rsp_z", rsp_z, 32'h7FFF_FFFF);
      checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
      checkOutput("to_rsp_invalid", 32'(rsp_invalid), 32'd0);
      checkOutput("to_mul_rst", 32'(mul_rst), 32'd1);
      stepCycle();
      sampleOutputs();
      checkOutput("to_mul_rst_pulse", 32'(mul_rst), 32'd0);
      respondOp(32'hDEAD_BEEF, 1'b1, 1'b1);
      sampleOutputs();
      checkOutput("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("stray_rsp_z_hold", rsp_z, 32'h7FFF_FFFF);
      stepCycle();

      // Result lands on the last watchdog cycle
      applyStimulus(0, 32'h4000_0000, 32'h4000_0000, 1'b1);
      waitGrant(4'b0001, "sim_grant");
      for (int i = 1; i <= TIMEOUT; i++) begin
         stepCycle();
         if (i == 1) req_valid = '0;
      end
      stepCycle();
      respondOp(32'h1234_5678, 1'b0, 1'b0);
      sampleOutputs();
      checkOutput("sim_rsp_valid", 32'(rsp_valid), 32'b0001);
      checkOutput("sim_rsp_z", rsp_z, 32'h1234_5678);
      checkOutput("sim_rsp_timeout", 32'(rsp_timeout), 32'd0);
      checkOutput("sim_mul_rst", 32'(mul_rst), 32'd0);
      stepCycle();

      // Reset during WAIT drops the operation
      applyStimulus(0, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
      waitGrant(4'b0001, "rst_grant");
      stepCycle();
      stepCycle();
      stepCycle();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) applyStimulus(k, rr_x[k], 32'h3F80_0000, 1'b1);
      stepCycle();
      sampleOutputs();
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_mul_rst", 32'(mul_rst), 32'd1);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_mul_valid", 32'(mul_valid), 32'd0);
      checkOutput("rst_rsp_z", rsp_z, 32'd0);
      checkOutput("rst_x_exp", 32'(mul_x_exp), 32'd0);
      stepCycle();
      rst_n = 1'b1;
      sampleOutputs();
      checkOutput("rst_after_grant", 32'(req_ready), 32'b0001);
      checkOutput("rst_after_mul_rst", 32'(mul_rst), 32'd0);
      checkOutput("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
